tdm_demux: RTL
==============

# tdm_demux

Time-division demultiplexer: the receive end of a multiplexed link. Takes one W-bit stream of time slots, aligns to a frame marker, and steers each slot into its own registered output channel with a per-channel valid strobe. It sits downstream of a slot multiplexer (N inputs selected onto one line) and restores the N parallel channels.

## Interface
Parameters:
- N_CH, 4, number of channels/slots per frame (≥2)
- W, 8, data width per slot

Ports:
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_data  input  W  slot data
- in_valid  input  1  in_data carries a slot this cycle
- frame_sync  input  1  qualifies current valid beat as slot 0; ignored when in_valid=0
- out_data  output  N_CH*W  channel k at bits [k*W +: W]
- out_valid  output  N_CH  one-cycle pulse, bit k = channel k updated
- frame_done  output  1  one-cycle pulse when slot N_CH-1 written
- locked  output  1  1 while in LOCKED state
- sync_err  output  1  one-cycle pulse on frame misalignment

## Operation
- Slot counter `slot`, width $clog2(N_CH), range 0..N_CH-1.
- States: HUNT, LOCKED.
- Reset (rst=1 at a clock edge): state=HUNT, slot=0, out_data=0, out_valid=0, frame_done=0, locked=0, sync_err=0. Reset wins over any concurrent beat.
- HUNT:
  - in_valid=1, frame_sync=1: write in_data to channel 0, pulse out_valid[0], slot=1, go LOCKED.
  - in_valid=1, frame_sync=0: beat dropped, no output change.
  - in_valid=0: hold.
- LOCKED, in_valid=1 (baseline):
  - Write in_data to channel `slot`, pulse out_valid[slot].
  - slot=N_CH-1: also pulse frame_done, slot wraps to 0.
  - Otherwise slot increments.
- LOCKED, in_valid=0: no change; gaps between beats of any length allowed.
- out_data channels hold their last value until rewritten; only the addressed channel changes.
- At most one out_valid bit high in any cycle.

## Timing
- Latency 1 cycle: beat sampled at edge n appears on out_data/out_valid after edge n (visible cycle n+1).
- out_valid, frame_done, sync_err are single-cycle pulses, 0 in every cycle without a qualifying beat.
- locked asserts in the cycle after the sync beat, same cycle as out_valid[0].
- Back-to-back beats: one slot per cycle, no bubbles.
- frame_done coincides with out_valid[N_CH-1].

## Configuration
- Macro TDM_DEMUX_SYNC_CHECK_EN.
- Defined: in LOCKED, for every valid beat:
  - frame_sync=1 and slot≠0: pulse sync_err, write beat to channel 0 (out_valid[0]), slot=1, stay LOCKED (resync). No frame_done.
  - frame_sync=0 and slot=0: pulse sync_err, drop beat, go HUNT (locked=0 next cycle).
  - frame_sync=1 and slot=0: normal.
- Not defined: frame_sync ignored in LOCKED, sync_err tied 0, only reset leaves LOCKED.

## Test plan
N_CH=4, W=8 unless noted.
- Reset: drive rst 2 cycles with in_valid=1 -> all outputs 0, locked=0; beats without frame_sync after reset -> no out_valid, locked stays 0.
- Lock + frame: beats 0x11(sync),0x22,0x33,0x44 back-to-back -> out_valid 0001,0010,0100,1000 on consecutive cycles, frame_done with 1000, out_data=0x44332211, locked=1.
- Gaps/wrap: same frame with 3 idle cycles between beats, then 0x55(sync) -> output timing follows beats only, second frame writes ch0=0x55 and other channels keep prior values.
- Misplaced sync (macro on): lock, send 0xA0,0xA1, then 0xB0 with frame_sync -> sync_err pulse, ch0=0xB0, next beat lands in ch1; macro off -> 0xB0 lands in ch2, sync_err=0.
- Missing sync (macro on): after full frame, beat 0xC0 without frame_sync -> sync_err pulse, no out_valid, locked=0; next sync beat relocks.
- Reset mid-frame: lock, write 2 slots, assert rst with in_valid=1 -> outputs cleared, state HUNT; N_CH=2 run confirms wrap after 2 slots.

Source files
------------

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: aligns a slotted W-bit stream to its frame marker
// and steers each slot into a registered per-channel output. Optional check: TDM_DEMUX_SYNC_CHECK_EN.
module tdm_demux #(
    parameter int N_CH = 4,
    parameter int W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W-1:0]      in_data,
    input  logic              in_valid,
    input  logic              frame_sync,
    output logic [N_CH*W-1:0] out_data,
    output logic [N_CH-1:0]   out_valid,
    output logic              frame_done,
    output logic              locked,
    output logic              sync_err
);
    // state  | meaning
    // HUNT   | waiting for a valid beat qualified by frame_sync
    // LOCKED | aligned; every valid beat goes to the current slot

    localparam int SW = $clog2(N_CH);
    localparam logic [SW-1:0] LAST = SW'(N_CH - 1);

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     slot_q, slot_d;
    logic              wr_en;
    logic [SW-1:0]     wr_ch;
    logic              fd_d, se_d;
    logic [N_CH*W-1:0] data_q;
    logic [N_CH-1:0]   valid_q;
    logic              fd_q, se_q;

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        wr_en   = 1'b0;
        wr_ch   = '0;
        fd_d    = 1'b0;
        se_d    = 1'b0;
        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    if (frame_sync) begin
                        wr_en   = 1'b1;
                        wr_ch   = '0;
                        slot_d  = SW'(1);
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    wr_en = 1'b1;
                    wr_ch = slot_q;
                    if (slot_q == LAST) begin
                        fd_d   = 1'b1;
                        slot_d = '0;
                    end else begin
                        slot_d = slot_q + SW'(1);
                    end
`ifdef TDM_DEMUX_SYNC_CHECK_EN
                    // Misalignment overrides the baseline advance computed above.
                    if (frame_sync && slot_q != '0) begin
                        se_d   = 1'b1;
                        wr_ch  = '0;
                        fd_d   = 1'b0;
                        slot_d = SW'(1);
                    end else if (!frame_sync && slot_q == '0) begin
                        se_d    = 1'b1;
                        wr_en   = 1'b0;
                        fd_d    = 1'b0;
                        slot_d  = '0;
                        state_d = HUNT;
                    end
`endif
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
            slot_q  <= '0;
            data_q  <= '0;
            valid_q <= '0;
            fd_q    <= 1'b0;
            se_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            fd_q    <= fd_d;
            se_q    <= se_d;
            valid_q <= '0;
            if (wr_en) begin
                valid_q[wr_ch]          <= 1'b1;
                data_q[wr_ch*W +: W]    <= in_data;
            end
        end
    end

    assign out_data   = data_q;
    assign out_valid  = valid_q;
    assign frame_done = fd_q;
    assign sync_err   = se_q;
    assign locked     = (state_q == LOCKED);

endmodule
